// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - shared widths, control bundle and MEM FSM state for the core pipeline
//   XLEN / RA_W  : default datapath and register-address widths
//   ctrl_t       : per-instruction control bundle (also carried by ID/EX)
//   mem_state_e  : MEM access FSM states
package pipeline_pkg;

    localparam int XLEN = 32;
    localparam int RA_W = 5;

    typedef struct packed {
        logic regWrite;
        logic memRead;
        logic memWrite;
        logic memtoReg;
    } ctrl_t;

    typedef enum logic {
        MEM_IDLE = 1'b0,
        MEM_WAIT = 1'b1
    } mem_state_e;

endpackage

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - MEM-stage access FSM, request/ready logic, optional watchdog
//   clk, rst        : core clock, synchronous active-high reset
//   mem_access_i    : valid load/store currently sitting in MEM
//   dmem_rvalid_i   : memory acknowledge
//   dmem_req_o      : memory request, held until acknowledged
//   ex_ready_o      : MEM can accept a new instruction this cycle
//   timeout_o       : access completes by watchdog this cycle (read data forced to 0)
//   mem_err_o       : sticky watchdog flag
// Optional feature: MEM_TIMEOUT_EN enables the watchdog; otherwise WAIT lasts until ack.
module mem_access_ctrl #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic mem_access_i,
    input  logic dmem_rvalid_i,
    output logic dmem_req_o,
    output logic ex_ready_o,
    output logic timeout_o,
    output logic mem_err_o
);
    import pipeline_pkg::*;

    mem_state_e state_q, state_d;
    logic       timeout_hit;

    // The watchdog completion behaves like an ack, so the request drops in
    // that cycle and the stall releases.
    assign dmem_req_o = mem_access_i & ~timeout_hit;
    assign ex_ready_o = ~(dmem_req_o & ~dmem_rvalid_i);
    assign timeout_o  = timeout_hit;

    always_comb begin
        state_d = state_q;
        case (state_q)
            MEM_IDLE: if (dmem_req_o && !dmem_rvalid_i) state_d = MEM_WAIT;
            MEM_WAIT: if (dmem_rvalid_i || timeout_hit) state_d = MEM_IDLE;
            default:  state_d = MEM_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= MEM_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q;

    // cnt_q counts completed WAIT cycles; the last permitted WAIT cycle completes the access.
    assign timeout_hit = (state_q == MEM_WAIT) && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    assign cnt_d       = (state_q == MEM_WAIT && state_d == MEM_WAIT) ? cnt_q + 1'b1 : '0;
    assign mem_err_o   = err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_q | timeout_hit;
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES == 0);
    assign timeout_hit    = 1'b0;
    assign mem_err_o      = 1'b0;
`endif

endmodule

// File: rtl/ex_mem_wb_pipe.sv
// rtl/ex_mem_wb_pipe.sv - EX/MEM and MEM/WB pipeline registers with stalled data-memory access
//   clk, rst                      : core clock, synchronous active-high reset
//   ex_valid, Ex_*                : instruction leaving EX (control, rd, ALU result, store data)
//   ex_ready                      : 0 stalls IF/ID/EX while a MEM access waits
//   dmem_req/we/addr/wdata        : data-memory request, stable while dmem_req is high
//   dmem_rvalid, dmem_rdata       : memory acknowledge and read data
//   Mem_regWrite/RegRd/aluResult  : MEM-stage forwarding source
//   Wb_regWrite/RegRd/writeData   : register-file write port / WB forwarding source
//   mem_err                       : sticky watchdog flag (only with MEM_TIMEOUT_EN)
// Optional feature: MEM_TIMEOUT_EN (watchdog in mem_access_ctrl).
module ex_mem_wb_pipe #(
    parameter int XLEN           = 32,
    parameter int RA_W           = 5,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ex_valid,
    input  logic            Ex_regWrite,
    input  logic            Ex_memRead,
    input  logic            Ex_memWrite,
    input  logic            Ex_memtoReg,
    input  logic [RA_W-1:0] Ex_RegRd,
    input  logic [XLEN-1:0] Ex_aluResult,
    input  logic [XLEN-1:0] Ex_storeData,
    output logic            ex_ready,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [XLEN-1:0] dmem_wdata,
    input  logic            dmem_rvalid,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic            Mem_regWrite,
    output logic [RA_W-1:0] Mem_RegRd,
    output logic [XLEN-1:0] Mem_aluResult,
    output logic            Wb_regWrite,
    output logic [RA_W-1:0] Wb_RegRd,
    output logic [XLEN-1:0] Wb_writeData,
    output logic            mem_err
);
    import pipeline_pkg::*;

    // EX/MEM register
    logic            mem_valid_q;
    ctrl_t           mem_ctrl_q;
    logic [RA_W-1:0] mem_rd_q;
    logic [XLEN-1:0] mem_alu_q;
    logic [XLEN-1:0] mem_sd_q;

    // MEM/WB register
    logic            wb_regwrite_q;
    logic [RA_W-1:0] wb_rd_q;
    logic [XLEN-1:0] wb_data_q;

    ctrl_t           ex_ctrl;
    logic            mem_access;
    logic            timeout;
    logic [XLEN-1:0] wb_data_d;

    assign ex_ctrl    = '{regWrite: Ex_regWrite, memRead: Ex_memRead,
                          memWrite: Ex_memWrite, memtoReg: Ex_memtoReg};
    assign mem_access = mem_valid_q & (mem_ctrl_q.memRead | mem_ctrl_q.memWrite);

    mem_access_ctrl #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_ctrl (
        .clk          (clk),
        .rst          (rst),
        .mem_access_i (mem_access),
        .dmem_rvalid_i(dmem_rvalid),
        .dmem_req_o   (dmem_req),
        .ex_ready_o   (ex_ready),
        .timeout_o    (timeout),
        .mem_err_o    (mem_err)
    );

    assign dmem_we    = mem_valid_q & mem_ctrl_q.memWrite;
    assign dmem_addr  = mem_alu_q;
    assign dmem_wdata = mem_sd_q;

    // A watchdog-completed load writes back 0 rather than whatever is on the bus.
    assign wb_data_d = mem_ctrl_q.memtoReg ? (timeout ? '0 : dmem_rdata) : mem_alu_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_valid_q   <= 1'b0;
            mem_ctrl_q    <= '0;
            mem_rd_q      <= '0;
            mem_alu_q     <= '0;
            mem_sd_q      <= '0;
            wb_regwrite_q <= 1'b0;
            wb_rd_q       <= '0;
            wb_data_q     <= '0;
        end else if (ex_ready) begin
            mem_valid_q   <= ex_valid;
            mem_ctrl_q    <= ex_ctrl;
            mem_rd_q      <= Ex_RegRd;
            mem_alu_q     <= Ex_aluResult;
            mem_sd_q      <= Ex_storeData;
            wb_regwrite_q <= mem_valid_q & mem_ctrl_q.regWrite;
            wb_rd_q       <= mem_rd_q;
            wb_data_q     <= wb_data_d;
        end
        // On a stall both registers hold; WB keeps re-presenting its write so
        // WB->EX forwarding stays valid for the stalled EX instruction.
    end

    assign Mem_regWrite  = mem_valid_q & mem_ctrl_q.regWrite;
    assign Mem_RegRd     = mem_rd_q;
    assign Mem_aluResult = mem_alu_q;
    assign Wb_regWrite   = wb_regwrite_q;
    assign Wb_RegRd      = wb_rd_q;
    assign Wb_writeData  = wb_data_q;

endmodule

// File: tb/tb_ex_mem_wb_pipe.sv
// tb/tb_ex_mem_wb_pipe.sv - directed vector bench for ex_mem_wb_pipe
module tb_ex_mem_wb_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid, Ex_regWrite, Ex_memRead, Ex_memWrite, Ex_memtoReg;
    logic [4:0]  Ex_RegRd;
    logic [31:0] Ex_aluResult, Ex_storeData;
    logic        ex_ready, dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic        Mem_regWrite;
    logic [4:0]  Mem_RegRd;
    logic [31:0] Mem_aluResult;
    logic        Wb_regWrite;
    logic [4:0]  Wb_RegRd;
    logic [31:0] Wb_writeData;
    logic        mem_err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ex_mem_wb_pipe #(.XLEN(32), .RA_W(5), .TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .ex_valid(ex_valid),
        .Ex_regWrite(Ex_regWrite), .Ex_memRead(Ex_memRead), .Ex_memWrite(Ex_memWrite),
        .Ex_memtoReg(Ex_memtoReg), .Ex_RegRd(Ex_RegRd), .Ex_aluResult(Ex_aluResult),
        .Ex_storeData(Ex_storeData), .ex_ready(ex_ready), .dmem_req(dmem_req),
        .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
        .Mem_regWrite(Mem_regWrite), .Mem_RegRd(Mem_RegRd), .Mem_aluResult(Mem_aluResult),
        .Wb_regWrite(Wb_regWrite), .Wb_RegRd(Wb_RegRd), .Wb_writeData(Wb_writeData),
        .mem_err(mem_err)
    );

    typedef logic [31:0] w_t;
    typedef struct {
        w_t valid, rw, mr, mw, m2r, rd, alu, sd, rvalid, rdata;
        w_t e_ready, e_req, e_we, e_addr, e_wdata;
        w_t e_mrw, e_mrd, e_wrw, e_wrd, e_wdat;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input w_t act, input w_t exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        ex_valid = 1'b0; Ex_regWrite = 1'b0; Ex_memRead = 1'b0; Ex_memWrite = 1'b0;
        Ex_memtoReg = 1'b0; Ex_RegRd = '0; Ex_aluResult = '0; Ex_storeData = '0;
        dmem_rvalid = 1'b0; dmem_rdata = '0;
    endtask

    task automatic drive_load(input logic [4:0] rd, input w_t addr);
        ex_valid = 1'b1; Ex_regWrite = 1'b1; Ex_memRead = 1'b1; Ex_memWrite = 1'b0;
        Ex_memtoReg = 1'b1; Ex_RegRd = rd; Ex_aluResult = addr; Ex_storeData = '0;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_ready"},  32'(ex_ready), 1);
        chk({tag, "_req"},    32'(dmem_req), 0);
        chk({tag, "_memrw"},  32'(Mem_regWrite), 0);
        chk({tag, "_memrd"},  32'(Mem_RegRd), 0);
        chk({tag, "_wbrw"},   32'(Wb_regWrite), 0);
        chk({tag, "_wbrd"},   32'(Wb_RegRd), 0);
        chk({tag, "_wbdata"}, Wb_writeData, 0);
        chk({tag, "_err"},    32'(mem_err), 0);
    endtask

    initial begin
        int low;
        //          valid rw mr mw m2r rd  alu     sd    rvalid rdata          rdy req we addr    wdata  mrw mrd wrw wrd wdat
        vecs[0] = '{1, 1, 0, 0, 0, 5, 'h1234, 0,    0, 0,             1, 0, 0, 0,     0,     1, 5, 0, 0, 0};
        vecs[1] = '{1, 1, 1, 0, 1, 7, 'h100,  0,    0, 0,             1, 0, 0, 0,     0,     1, 7, 1, 5, 'h1234};
        vecs[2] = '{1, 1, 0, 0, 0, 3, 'h33,   0,    0, 0,             0, 1, 0, 'h100, 0,     1, 7, 1, 5, 'h1234};
        vecs[3] = '{1, 1, 0, 0, 0, 3, 'h33,   0,    0, 0,             0, 1, 0, 'h100, 0,     1, 7, 1, 5, 'h1234};
        vecs[4] = '{1, 1, 0, 0, 0, 3, 'h33,   0,    0, 0,             0, 1, 0, 'h100, 0,     1, 7, 1, 5, 'h1234};
        vecs[5] = '{1, 1, 0, 0, 0, 3, 'h33,   0,    1, 'hDEADBEEF,     1, 1, 0, 'h100, 0,     1, 3, 1, 7, 'hDEADBEEF};
        vecs[6] = '{1, 0, 0, 1, 0, 0, 'h40,   'h55, 0, 0,             1, 0, 0, 0,     0,     0, 0, 1, 3, 'h33};
        vecs[7] = '{0, 1, 0, 0, 0, 0, 0,      0,    1, 'hFFFFFFFF,     1, 1, 1, 'h40,  'h55,  0, 0, 0, 0, 'h40};
        vecs[8] = '{0, 0, 0, 0, 0, 0, 0,      0,    1, 'h12345678,     1, 0, 0, 0,     0,     0, 0, 0, 0, 0};

        drive_idle();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_state("rst");

        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 9; i++) begin
            vec_t v;
            v = vecs[i];
            ex_valid = v.valid[0]; Ex_regWrite = v.rw[0]; Ex_memRead = v.mr[0];
            Ex_memWrite = v.mw[0]; Ex_memtoReg = v.m2r[0]; Ex_RegRd = v.rd[4:0];
            Ex_aluResult = v.alu; Ex_storeData = v.sd;
            dmem_rvalid = v.rvalid[0]; dmem_rdata = v.rdata;
            #1;
            chk($sformatf("v%0d_ready", i), 32'(ex_ready), v.e_ready);
            chk($sformatf("v%0d_req", i), 32'(dmem_req), v.e_req);
            if (v.e_req != 0) begin
                chk($sformatf("v%0d_we", i), 32'(dmem_we), v.e_we);
                chk($sformatf("v%0d_addr", i), dmem_addr, v.e_addr);
                chk($sformatf("v%0d_wdata", i), dmem_wdata, v.e_wdata);
            end
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_memrw", i), 32'(Mem_regWrite), v.e_mrw);
            chk($sformatf("v%0d_memrd", i), 32'(Mem_RegRd), v.e_mrd);
            chk($sformatf("v%0d_wbrw", i), 32'(Wb_regWrite), v.e_wrw);
            chk($sformatf("v%0d_wbrd", i), 32'(Wb_RegRd), v.e_wrd);
            chk($sformatf("v%0d_wbdata", i), Wb_writeData, v.e_wdat);
            @(negedge clk);
        end
        drive_idle();

        // Reset while a load waits in MEM, then a late ack that must be ignored.
        @(negedge clk);
        drive_load(5'd9, 32'h200);
        @(posedge clk);
        @(negedge clk);
        drive_idle();
        #1;
        chk("rw_req_pending", 32'(dmem_req), 1);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk_reset_state("rw");
        @(negedge clk);
        rst = 1'b0;
        dmem_rvalid = 1'b1; dmem_rdata = 32'hABCD;
        #1;
        chk("rw_late_req", 32'(dmem_req), 0);
        chk("rw_late_ready", 32'(ex_ready), 1);
        @(posedge clk);
        #1;
        chk("rw_late_wbrw", 32'(Wb_regWrite), 0);
        chk("rw_late_wbdata", Wb_writeData, 0);
        @(negedge clk);
        drive_idle();

        // Load with no ack: watchdog completion or indefinite wait.
        @(negedge clk);
        drive_load(5'd11, 32'h300);
        @(posedge clk);
        @(negedge clk);
        drive_idle();
        low = 0;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (ex_ready) break;
            low++;
            @(posedge clk);
            @(negedge clk);
        end
`ifdef MEM_TIMEOUT_EN
        chk("to_stall_cycles", 32'(low), 4);
        @(posedge clk);
        #1;
        chk("to_wbrw", 32'(Wb_regWrite), 1);
        chk("to_wbrd", 32'(Wb_RegRd), 11);
        chk("to_wbdata", Wb_writeData, 0);
        chk("to_err", 32'(mem_err), 1);
        repeat (3) @(posedge clk);
        #1;
        chk("to_err_sticky", 32'(mem_err), 1);
        chk("to_req_idle", 32'(dmem_req), 0);
`else
        chk("nt_stall_cycles", 32'(low), 10);
        chk("nt_err", 32'(mem_err), 0);
        dmem_rvalid = 1'b1; dmem_rdata = 32'h77;
        #1;
        chk("nt_ready_on_ack", 32'(ex_ready), 1);
        @(posedge clk);
        #1;
        chk("nt_wbrd", 32'(Wb_RegRd), 11);
        chk("nt_wbdata", Wb_writeData, 32'h77);
        chk("nt_err_after", 32'(mem_err), 0);
        @(negedge clk);
        drive_idle();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ex_mem_wb_pipe.md
# ex_mem_wb_pipe

Holds the EX/MEM and MEM/WB pipeline registers of the 5-stage core, sequences the data-memory access in MEM, and produces the `Mem_*` and `Wb_*` destination/control signals that the forwarding unit and register-file write port consume. A load or store in MEM that waits on memory back-pressures EX through `ex_ready`. While the stall lasts, the WB instruction is kept visible so forwarding stays correct.

## Interface
Parameters:
- `XLEN`, 32: datapath width.
- `RA_W`, 5: register-address width.
- `TIMEOUT_CYCLES`, 255: watchdog limit. Used only with `MEM_TIMEOUT_EN`.

Ports (one clock `clk`; reset `rst` is synchronous and active-high):
- `clk`  in  1  core clock.
- `rst`  in  1  synchronous active-high reset.
- `ex_valid`  in  1  EX holds a real instruction (0 = bubble or flushed).
- `Ex_regWrite`, `Ex_memRead`, `Ex_memWrite`, `Ex_memtoReg`  in  1 each  EX control.
- `Ex_RegRd`  in  RA_W  EX destination.
- `Ex_aluResult`  in  XLEN  ALU result / memory address.
- `Ex_storeData`  in  XLEN  store data.
- `ex_ready`  out  1  MEM can accept; 0 stalls IF/ID/EX.
- `dmem_req`  out  1  memory request, held until acknowledged.
- `dmem_we`  out  1  write enable.
- `dmem_addr`  out  XLEN  memory address.
- `dmem_wdata`  out  XLEN  write data.
- `dmem_rvalid`  in  1  acknowledge (read data valid for loads).
- `dmem_rdata`  in  XLEN  read data.
- `Mem_regWrite`  out  1  valid & regWrite of MEM.
- `Mem_RegRd`  out  RA_W  MEM destination.
- `Mem_aluResult`  out  XLEN  forwarding value from MEM.
- `Wb_regWrite`  out  1  valid & regWrite of WB.
- `Wb_RegRd`  out  RA_W  WB destination.
- `Wb_writeData`  out  XLEN  write-back value.
- `mem_err`  out  1  sticky timeout flag. Tied 0 without `MEM_TIMEOUT_EN`.

## Operation
- MEM control FSM:
  - States: IDLE (no pending access) and WAIT (memory op in MEM, unacknowledged).
  - IDLE→WAIT when a memory op enters MEM and `dmem_rvalid` is not seen that cycle.
  - WAIT→IDLE on `dmem_rvalid`.
- Memory request: `dmem_req` = `mem_valid & (memRead | memWrite) & !done`. `dmem_addr`/`dmem_wdata`/`dmem_we` come from the MEM register and are stable while `dmem_req` is high.
- Back-pressure: `ex_ready` = `!(dmem_req & !dmem_rvalid)`, combinational. Zero-wait memory (ack in the request cycle) causes no stall.
- Advance (`ex_ready`=1):
  - MEM←EX; a bubble is loaded when `ex_valid`=0.
  - WB←MEM, with `Wb_writeData` = `memtoReg ? dmem_rdata : aluResult`.
- Stall (`ex_ready`=0): MEM holds. WB also holds with `Wb_regWrite` unchanged; the idempotent register-file rewrite is intended so WB→EX forwarding survives the stall.
- Gating: `Mem_regWrite`/`Wb_regWrite` are forced 0 for bubbles. `rd`=0 is passed through unchanged; the forwarding unit filters it.
- Ignored inputs: `dmem_rvalid` while `dmem_req`=0. `dmem_rdata` for stores.
- Reset: all valid bits 0, all regWrite outputs 0, `RegRd`/data registers 0, FSM IDLE, `dmem_req` 0, `ex_ready` 1, `mem_err` 0.
- Reset during WAIT aborts the access; `dmem_req` is low from the first cycle after the reset edge. Memory must tolerate the dropped request.

## Timing
- EX→MEM: 1 cycle. MEM→WB: 1 cycle plus wait cycles.
- Load with ack k cycles after first `dmem_req`: `ex_ready` low for k cycles, and `Wb_writeData` shows the load data on the edge after ack.
- Ack and a new EX instruction in the same cycle: both transfer on the same edge.
- Back-to-back memory ops: the next request is raised the cycle after the previous ack.

## Configuration
- `MEM_TIMEOUT_EN` defined: a counter runs in WAIT. On reaching `TIMEOUT_CYCLES` the access completes as if acknowledged with `dmem_rdata` treated as 0, and `mem_err` sets and stays set until `rst`.
- `MEM_TIMEOUT_EN` undefined: no counter, WAIT lasts indefinitely, and `mem_err` is constant 0.

## Structure
- Shared package `pipeline_pkg`:
  - `XLEN` and `RA_W` constants.
  - Control-bundle typedef (`regWrite`, `memRead`, `memWrite`, `memtoReg`), also used by the ID/EX register.
  - MEM FSM state enum.
- Sub-module `mem_access_ctrl`: IDLE/WAIT FSM, request/ready logic, optional watchdog. The top level holds the two pipeline registers.

## Test plan
- ALU op `rd`=5, `aluResult`=0x1234, no stalls → `Mem_regWrite`=1/`Mem_RegRd`=5 at cycle+1, then `Wb_RegRd`=5/`Wb_writeData`=0x1234 at cycle+2.
- Load `rd`=7, `dmem_rvalid` 3 cycles after request, `rdata`=0xDEADBEEF → `ex_ready` low 3 cycles, WB holds prior instruction with `Wb_regWrite` unchanged, then `Wb_writeData`=0xDEADBEEF.
- Store to 0x40, data 0x55, zero-wait ack → no stall, `dmem_we`=1, `Wb_regWrite`=0.
- `ex_valid`=0 with `Ex_regWrite`=1 → `Mem_regWrite`=0 and `Wb_regWrite`=0 in the following cycles.
- `rst` asserted during WAIT → `dmem_req`=0 and all outputs at reset values after the edge; a late `dmem_rvalid` pulse is ignored.
- With `MEM_TIMEOUT_EN`, `TIMEOUT_CYCLES`=4, no ack → completes after 4 WAIT cycles, `Wb_writeData`=0 for a load, `mem_err`=1 and sticky.
